demux4_stream: RTL and testbench

Registered 1-to-4 stream demultiplexer: the distribution counterpart of the mux4 selection cell. It accepts one WIDTH-bit word per cycle on a valid/ready input port and routes it to one of four valid/ready output lanes. The lane is chosen by the S1:S0 select pair, with the same encoding mux4 uses (I0..I3 ↔ lanes 0..3). It sits between a single producer and four consumers in MCU datapaths, and each lane buffers independently.

---
 rtl/demux4_stream.sv | 138 +++++++++++++
 tb/tb_demux4_stream.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer with an independent FIFO per lane.
// Define DEMUX4_STREAM_SKID_EN for 2-entry lanes, which removes the ZR->IR path.

module demux4_stream_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             zr,
  output logic [WIDTH-1:0] z,
  output logic             zv,
  output logic             rdy
);
  logic pop;
  assign pop = zv && zr;

`ifdef DEMUX4_STREAM_SKID_EN
  // Occupancy is {full, zv}: 0, 1 or 2 words. The skid entry holds the second word.
  logic             full;
  logic [WIDTH-1:0] skid;

  assign rdy = !full;

  always_ff @(posedge clk) begin
    if (rst) begin
      z    <= '0;
      zv   <= 1'b0;
      full <= 1'b0;
      skid <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!zv) begin
            z  <= din;
            zv <= 1'b1;
          end else begin
            skid <= din;
            full <= 1'b1;
          end
        end
        2'b01: begin
          if (full) begin
            z    <= skid;
            full <= 1'b0;
          end else begin
            zv <= 1'b0;
          end
        end
        2'b11: begin
          if (full) begin
            z    <= skid;
            skid <= din;
          end else begin
            z <= din;
          end
        end
        default: ;
      endcase
    end
  end
`else
  // Pass-through ready lets a full lane accept in the same cycle it drains.
  assign rdy = !zv || zr;

  always_ff @(posedge clk) begin
    if (rst) begin
      z  <= '0;
      zv <= 1'b0;
    end else if (push) begin
      z  <= din;
      zv <= 1'b1;
    end else if (pop) begin
      zv <= 1'b0;
    end
  end
`endif
endmodule

module demux4_stream #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] I,
  input  logic             IV,
  output logic             IR,
  input  logic             S0,
  input  logic             S1,
  output logic [WIDTH-1:0] Z0,
  output logic [WIDTH-1:0] Z1,
  output logic [WIDTH-1:0] Z2,
  output logic [WIDTH-1:0] Z3,
  output logic             ZV0,
  output logic             ZV1,
  output logic             ZV2,
  output logic             ZV3,
  input  logic             ZR0,
  input  logic             ZR1,
  input  logic             ZR2,
  input  logic             ZR3,
  output logic             BUSY
);
  localparam int NUM_LANES = 4;

  logic [1:0]                      sel;
  logic [NUM_LANES-1:0]            zr, zv, rdy, push;
  logic [NUM_LANES-1:0][WIDTH-1:0] z;

  assign sel = {S1, S0};
  assign zr  = {ZR3, ZR2, ZR1, ZR0};
  assign IR  = rdy[sel];

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    assign push[n] = IV && IR && (sel == n[1:0]);

    demux4_stream_lane #(.WIDTH(WIDTH)) u_lane (
      .clk  (CLK),
      .rst  (RST),
      .push (push[n]),
      .din  (I),
      .zr   (zr[n]),
      .z    (z[n]),
      .zv   (zv[n]),
      .rdy  (rdy[n])
    );
  end

  assign {Z3, Z2, Z1, Z0}     = z;
  assign {ZV3, ZV2, ZV1, ZV0} = zv;

  // Registered from lane state, so BUSY trails occupancy changes by one cycle.
  always_ff @(posedge CLK) begin
    if (RST) BUSY <= 1'b0;
    else     BUSY <= |zv;
  end
endmodule

// File: tb/tb_demux4_stream.sv
// Randomized and directed bench for demux4_stream against a per-lane queue model.
// Lane depth follows DEMUX4_STREAM_SKID_EN.

module tb_demux4_stream;
  localparam int W = 8;
`ifdef DEMUX4_STREAM_SKID_EN
  localparam int D = 2;
`else
  localparam int D = 1;
`endif

  logic         CLK = 1'b0;
  logic         RST, IV, IR, BUSY;
  logic [W-1:0] I;
  logic [1:0]   s;
  logic [3:0]   zr;
  logic [W-1:0] Z0, Z1, Z2, Z3;
  logic         ZV0, ZV1, ZV2, ZV3;
  logic [W-1:0] z [4];
  logic [3:0]   zv;

  assign z[0] = Z0;
  assign z[1] = Z1;
  assign z[2] = Z2;
  assign z[3] = Z3;
  assign zv   = {ZV3, ZV2, ZV1, ZV0};

  demux4_stream #(.WIDTH(W)) dut (
    .CLK(CLK), .RST(RST), .I(I), .IV(IV), .IR(IR), .S0(s[0]), .S1(s[1]),
    .Z0(Z0), .Z1(Z1), .Z2(Z2), .Z3(Z3),
    .ZV0(ZV0), .ZV1(ZV1), .ZV2(ZV2), .ZV3(ZV3),
    .ZR0(zr[0]), .ZR1(zr[1]), .ZR2(zr[2]), .ZR3(zr[3]),
    .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int           n_vec, n_bad;
  logic [W-1:0] q [4][$];
  logic         busy_e;
  logic         dut_acc;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lane can take a word if it has room, or (single-entry lanes) it is draining now.
  function automatic logic ir_model();
    if (D == 1) return (q[s].size() == 0) || zr[s];
    return q[s].size() < D;
  endfunction

  // One clock: check outputs against the model, take the edge, advance the model.
  task automatic step();
    logic ir_e, any;
    #1;
    ir_e = ir_model();
    dut_acc = IV && IR;
    chk("IR", IR, ir_e);
    chk("BUSY", BUSY, busy_e);
    for (int n = 0; n < 4; n++) begin
      chk($sformatf("ZV%0d", n), zv[n], q[n].size() != 0);
      if (q[n].size() != 0) chk($sformatf("Z%0d", n), z[n], q[n][0]);
    end
    @(posedge CLK);
    if (RST) begin
      for (int n = 0; n < 4; n++) q[n].delete();
      busy_e = 1'b0;
    end else begin
      any = 1'b0;
      for (int n = 0; n < 4; n++) any = any | (q[n].size() != 0);
      busy_e = any;
      for (int n = 0; n < 4; n++)
        if (q[n].size() != 0 && zr[n]) void'(q[n].pop_front());
      if (IV && ir_e) q[s].push_back(I);
    end
    #1;
  endtask

  logic [W-1:0] bp [3];
  int           idx;

  initial begin
    n_vec = 0; n_bad = 0; busy_e = 1'b0; dut_acc = 1'b0;
    bp[0] = 8'hA0; bp[1] = 8'hA1; bp[2] = 8'hA2;
    RST = 1'b1; IV = 1'b0; s = 2'd0; I = '0; zr = 4'hF;

    // Reset, with a word presented that must be ignored
    IV = 1'b1; I = 8'hEE;
    step(); step();
    chk("rst_zv", zv, 4'h0);
    chk("rst_busy", BUSY, 1'b0);
    for (int n = 0; n < 4; n++) chk($sformatf("rst_Z%0d", n), z[n], 0);
    RST = 1'b0; IV = 1'b0;

    // Routing on all four lanes
    for (int k = 0; k < 4; k++) begin
      s = k[1:0]; I = 8'h11 * (k + 1); IV = 1'b1;
      step();
      chk("route_zv", zv, 4'h1 << k);
      chk("route_z", z[k], 8'h11 * (k + 1));
    end
    IV = 1'b0; step(); step();

    // Backpressure on lane 2
    zr = 4'b1011; s = 2'd2; idx = 0;
    repeat (4) begin
      IV = (idx < 3); I = (idx < 3) ? bp[idx] : 8'h00;
      step();
      if (dut_acc) idx++;
      chk("bp_hold", Z2, 8'hA0);
    end
    chk("bp_accepts", idx, D);
    zr = 4'hF;
    repeat (6) begin
      IV = (idx < 3); I = (idx < 3) ? bp[idx] : 8'h00;
      step();
      if (dut_acc) idx++;
    end
    chk("bp_all", idx, 3);
    IV = 1'b0; step(); step();

    // Stalled full lane 0 does not block lane 3
    zr = 4'b1110; s = 2'd0; IV = 1'b1;
    for (int k = 0; k < D; k++) begin
      I = 8'hC0 + k[7:0];
      step();
    end
    s = 2'd3; I = 8'h5A;
    step();
    chk("ind_acc", dut_acc, 1'b1);
    chk("ind_ZV3", ZV3, 1'b1);
    chk("ind_Z3", Z3, 8'h5A);
    chk("ind_Z0", Z0, 8'hC0);
    IV = 1'b0; zr = 4'hF;
    repeat (3) step();

    // Simultaneous push and pop on lane 1
    zr = 4'b1101; s = 2'd1; I = 8'h10; IV = 1'b1;
    step();
    zr = 4'hF; I = 8'h20;
    step();
    chk("pp_acc", dut_acc, 1'b1);
    chk("pp_ZV1", ZV1, 1'b1);
    chk("pp_Z1", Z1, 8'h20);
    IV = 1'b0; step();

    // Reset mid-operation with IV high
    zr = 4'h0; IV = 1'b1;
    s = 2'd0; I = 8'h61; step();
    s = 2'd3; I = 8'h63; step();
    RST = 1'b1; s = 2'd0; I = 8'h77;
    step();
    RST = 1'b0;
    chk("rm_zv", zv, 4'h0);
    chk("rm_busy", BUSY, 1'b0);
    zr = 4'hF;
    step();
    chk("rm_next_acc", dut_acc, 1'b1);
    chk("rm_Z0", Z0, 8'h77);
    IV = 1'b0; step(); step();

    // Random traffic, occasional reset
    repeat (10000) begin
      RST = ($urandom_range(999) == 0);
      IV  = ($urandom_range(3) != 0);
      s   = 2'($urandom);
      I   = 8'($urandom);
      zr  = 4'($urandom);
      step();
    end
    RST = 1'b0; IV = 1'b0; zr = 4'hF;
    repeat (4) step();
    chk("drain_zv", zv, 4'h0);
    chk("drain_busy", BUSY, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
